// File: rtl/memory_rank_timed_bfm.sv
// Timed bus-functional model of one memory rank: per-bank state machines plus a DQ burst timeline.
// Optional REFRESH_SUPPORT_EN enables the REF command and the REFRESHING bank state.
module memory_rank_timed_bfm #(
    parameter int BGWIDTH      = 2,
    parameter int BKWIDTH      = 2,
    parameter int RWIDTH       = 15,
    parameter int BURST_LENGTH = 8,
    parameter int tCL          = 16,
    parameter int tCWL         = 12,
    parameter int tRCD         = 16,
    parameter int tRP          = 16,
    parameter int tRFC         = 256
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              cmd_valid,
    input  logic [2:0]                                        cmd_op,
    input  logic [BGWIDTH-1:0]                                cmd_bg,
    input  logic [BKWIDTH-1:0]                                cmd_bk,
    input  logic [RWIDTH-1:0]                                 cmd_row,
    output logic                                              rd_valid,
    output logic                                              wr_valid,
    output logic [BGWIDTH+BKWIDTH-1:0]                        dq_bank,
    output logic [((BURST_LENGTH/2 > 1) ? $clog2(BURST_LENGTH/2) : 1)-1:0] dq_beat,
    output logic [(2**(BGWIDTH+BKWIDTH))-1:0]                 bank_open,
    output logic                                              err_state,
    output logic                                              err_timing,
    output logic                                              err_collision,
    output logic [15:0]                                       err_count
);

    // state          | meaning
    // ST_IDLE        | bank precharged, accepts ACT / PRE (no-op) / REF
    // ST_ACTIVATING  | ACT in flight, counter runs down tRCD
    // ST_ACTIVE      | row open, accepts RD / WR / PRE
    // ST_PRECHARGING | PRE in flight, counter runs down tRP
    // ST_REFRESHING  | REF in flight, counter runs down tRFC (refresh builds only)

    localparam int BW      = BGWIDTH + BKWIDTH;
    localparam int NUMBANK = 2 ** BW;
    localparam int HALF    = BURST_LENGTH / 2;
    localparam int BEATW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int MAXLAT  = (tCL > tCWL) ? tCL : tCWL;
    localparam int DEPTH   = MAXLAT - 1 + HALF;
    localparam int MAXT1   = (tRCD > tRP) ? tRCD : tRP;
    localparam int MAXT    = (tRFC > MAXT1) ? tRFC : MAXT1;
    localparam int CW      = $clog2(MAXT + 1);

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ACT = 3'd1;
    localparam logic [2:0] OP_RD  = 3'd2;
    localparam logic [2:0] OP_WR  = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4;
`ifdef REFRESH_SUPPORT_EN
    localparam logic [2:0] OP_REF = 3'd5;
`endif

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACTIVATING  = 3'd1,
        ST_ACTIVE      = 3'd2,
        ST_PRECHARGING = 3'd3
`ifdef REFRESH_SUPPORT_EN
        , ST_REFRESHING = 3'd4
`endif
    } bank_st_e;

    bank_st_e          state_q [NUMBANK];
    bank_st_e          state_d [NUMBANK];
    logic [CW-1:0]     cnt_q   [NUMBANK];
    logic [CW-1:0]     cnt_d   [NUMBANK];
    // Open row is kept for hierarchical inspection only; no port exposes it.
    logic [RWIDTH-1:0] unused_row_q [NUMBANK];
    logic [RWIDTH-1:0] unused_row_d [NUMBANK];

    // Burst timeline: entry k is registered onto DQ k edges from now.
    logic [DEPTH-1:0]  tl_v_q, tl_v_d, tl_wr_q, tl_wr_d;
    logic [BW-1:0]     tl_bank_q [DEPTH];
    logic [BW-1:0]     tl_bank_d [DEPTH];
    logic [BEATW-1:0]  tl_beat_q [DEPTH];
    logic [BEATW-1:0]  tl_beat_d [DEPTH];

    logic              out_v_q, out_v_d, out_wr_q, out_wr_d;
    logic [BW-1:0]     out_bank_q, out_bank_d;
    logic [BEATW-1:0]  out_beat_q, out_beat_d;
    logic              err_st_q, err_st_d, err_tm_q, err_tm_d, err_co_q, err_co_d;
    logic [15:0]       err_count_q, err_count_d;

    logic [NUMBANK-1:0] busy, active;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUMBANK; b++) begin
                state_q[b]      <= ST_IDLE;
                cnt_q[b]        <= '0;
                unused_row_q[b] <= '0;
            end
            tl_v_q  <= '0;
            tl_wr_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tl_bank_q[k] <= '0;
                tl_beat_q[k] <= '0;
            end
            out_v_q     <= 1'b0;
            out_wr_q    <= 1'b0;
            out_bank_q  <= '0;
            out_beat_q  <= '0;
            err_st_q    <= 1'b0;
            err_tm_q    <= 1'b0;
            err_co_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            unused_row_q <= unused_row_d;
            tl_v_q       <= tl_v_d;
            tl_wr_q      <= tl_wr_d;
            tl_bank_q    <= tl_bank_d;
            tl_beat_q    <= tl_beat_d;
            out_v_q      <= out_v_d;
            out_wr_q     <= out_wr_d;
            out_bank_q   <= out_bank_d;
            out_beat_q   <= out_beat_d;
            err_st_q     <= err_st_d;
            err_tm_q     <= err_tm_d;
            err_co_q     <= err_co_d;
            err_count_q  <= err_count_d;
        end
    end

    // Next-state logic
    always_comb begin
        logic [DEPTH-1:0] v_n, wr_n, win;
        logic [BW-1:0]    bank_n [DEPTH];
        logic [BEATW-1:0] beat_n [DEPTH];
        logic [BW-1:0]    tgt;
        logic [16:0]      sum;
        int               lat;

        state_d      = state_q;
        cnt_d        = cnt_q;
        unused_row_d = unused_row_q;
        v_n          = tl_v_q;
        wr_n         = tl_wr_q;
        bank_n       = tl_bank_q;
        beat_n       = tl_beat_q;
        win          = '0;
        err_st_d     = 1'b0;
        err_tm_d     = 1'b0;
        err_co_d     = 1'b0;
        tgt          = {cmd_bg, cmd_bk};
        lat          = (cmd_op == OP_WR) ? tCWL : tCL;

        for (int b = 0; b < NUMBANK; b++) begin
            if (state_q[b] != ST_IDLE && state_q[b] != ST_ACTIVE) begin
                if (cnt_q[b] == '0)
                    state_d[b] = (state_q[b] == ST_ACTIVATING) ? ST_ACTIVE : ST_IDLE;
                else
                    cnt_d[b] = cnt_q[b] - 1'b1;
            end
        end

        for (int k = 0; k < DEPTH; k++)
            win[k] = (k >= lat - 1) && (k < lat - 1 + HALF);

        if (cmd_valid) begin
            case (cmd_op)
                OP_NOP: ;
                OP_ACT: begin
                    if (busy[tgt])        err_tm_d = 1'b1;
                    else if (active[tgt]) err_st_d = 1'b1;
                    else begin
                        state_d[tgt]      = ST_ACTIVATING;
                        cnt_d[tgt]        = CW'(tRCD - 1);
                        unused_row_d[tgt] = cmd_row;
                    end
                end
                OP_RD, OP_WR: begin
                    if (busy[tgt])                err_tm_d = 1'b1;
                    else if (!active[tgt])        err_st_d = 1'b1;
                    else if (|(tl_v_q & win))     err_co_d = 1'b1;
                    else begin
                        for (int k = 0; k < DEPTH; k++) begin
                            if (win[k]) begin
                                v_n[k]    = 1'b1;
                                wr_n[k]   = (cmd_op == OP_WR);
                                bank_n[k] = tgt;
                                beat_n[k] = BEATW'(k - lat + 1);
                            end
                        end
                    end
                end
                OP_PRE: begin
                    if (busy[tgt]) err_tm_d = 1'b1;
                    else if (active[tgt]) begin
                        state_d[tgt] = ST_PRECHARGING;
                        cnt_d[tgt]   = CW'(tRP - 1);
                    end
                end
`ifdef REFRESH_SUPPORT_EN
                OP_REF: begin
                    if (|busy || |active) err_st_d = 1'b1;
                    else begin
                        for (int b = 0; b < NUMBANK; b++) begin
                            state_d[b] = ST_REFRESHING;
                            cnt_d[b]   = CW'(tRFC - 1);
                        end
                    end
                end
`endif
                default: err_st_d = 1'b1;
            endcase
        end

        out_v_d    = v_n[0];
        out_wr_d   = wr_n[0];
        out_bank_d = bank_n[0];
        out_beat_d = beat_n[0];
        tl_v_d     = {1'b0, v_n[DEPTH-1:1]};
        tl_wr_d    = {1'b0, wr_n[DEPTH-1:1]};
        for (int k = 0; k < DEPTH - 1; k++) begin
            tl_bank_d[k] = bank_n[k+1];
            tl_beat_d[k] = beat_n[k+1];
        end
        tl_bank_d[DEPTH-1] = '0;
        tl_beat_d[DEPTH-1] = '0;

        sum         = {1'b0, err_count_q} + {16'd0, err_st_d} + {16'd0, err_tm_d} + {16'd0, err_co_d};
        err_count_d = sum[16] ? 16'hFFFF : sum[15:0];
    end

    // Output decode: a bank whose counter has expired counts as already settled.
    always_comb begin
        busy   = '0;
        active = '0;
        for (int b = 0; b < NUMBANK; b++) begin
            case (state_q[b])
                ST_IDLE:       ;
                ST_ACTIVE:     active[b] = 1'b1;
                ST_ACTIVATING: begin
                    if (cnt_q[b] == '0) active[b] = 1'b1;
                    else                busy[b]   = 1'b1;
                end
                default:       busy[b] = (cnt_q[b] != '0);
            endcase
        end
    end

    assign bank_open     = active;
    assign rd_valid      = out_v_q & ~out_wr_q;
    assign wr_valid      = out_v_q & out_wr_q;
    assign dq_bank       = out_bank_q;
    assign dq_beat       = out_beat_q;
    assign err_state     = err_st_q;
    assign err_timing    = err_tm_q;
    assign err_collision = err_co_q;
    assign err_count     = err_count_q;

endmodule

// File: doc/memory_rank_timed_bfm.md
MEMORY_RANK_TIMED_BFM -- requirements
Module: memory_rank_timed_bfm

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- BGWIDTH, 2, bank-group bits
- BKWIDTH, 2, bank bits (NUMBANK = 2^(BGWIDTH+BKWIDTH))
- RWIDTH, 15, row bits
- BURST_LENGTH, 8, beats per burst (DQ busy BURST_LENGTH/2 cycles)
- tCL, 16, RD-to-data cycles
- tCWL, 12, WR-to-data cycles
- tRCD, 16, ACT-to-ACTIVE cycles
- tRP, 16, PRE-to-IDLE cycles
- tRFC, 256, REF busy cycles
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, sole clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- cmd_valid, in, 1, command present this cycle
- cmd_op, in, 3, 0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 illegal
- cmd_bg, in, BGWIDTH, target bank group
- cmd_bk, in, BKWIDTH, target bank
- cmd_row, in, RWIDTH, row for ACT
- rd_valid, out, 1, read burst beat-pair on DQ
- wr_valid, out, 1, write burst beat-pair expected on DQ
- dq_bank, out, BGWIDTH+BKWIDTH, bank owning current burst
- dq_beat, out, clog2(BURST_LENGTH/2), cycle index within burst
- bank_open, out, NUMBANK, bit i high when bank i ACTIVE
- err_state, out, 1, pulse: command illegal for stable bank state
- err_timing, out, 1, pulse: command hit a bank in a timed transition
- err_collision, out, 1, pulse: new burst overlaps scheduled burst
- err_count, out, 16, saturating total of error pulses
REQ-003 SHALL use one clock; reset is asynchronous and active-low (ports clk, rst_n).

Function
REQ-004 Each bank SHALL hold state IDLE, ACTIVATING, ACTIVE, PRECHARGING or REFRESHING, plus open row and down-counter.
REQ-005 ACT to IDLE bank at cycle T SHALL enter ACTIVATING, latch cmd_row, become ACTIVE at T+tRCD.
REQ-006 PRE to ACTIVE bank SHALL enter PRECHARGING, become IDLE after tRP cycles; PRE to IDLE bank SHALL be a legal no-op.
REQ-007 RD/WR to ACTIVE bank at T SHALL schedule burst starting T+tCL (RD) or T+tCWL (WR), lasting BURST_LENGTH/2 cycles, dq_beat 0..BURST_LENGTH/2-1, dq_bank = target.
REQ-008 Command to bank in ACTIVATING/PRECHARGING/REFRESHING SHALL pulse err_timing at T+1 and be ignored.
REQ-009 RD/WR to IDLE bank, ACT to ACTIVE bank, or op 6-7 SHALL pulse err_state at T+1 and be ignored.
REQ-010 Burst whose data window overlaps any scheduled burst SHALL pulse err_collision at T+1 and be dropped; back-to-back (adjacent) windows SHALL be legal.
REQ-011 rd_valid and wr_valid SHALL never be high together.
REQ-012 err_count SHALL add number of error pulses per cycle, saturating at 16'hFFFF.
REQ-013 cmd_valid low or NOP SHALL change no state; counters keep running.

Reset
REQ-014 On rst_n low, all banks SHALL go IDLE, counters and scheduled bursts clear, all outputs 0, immediately and mid-burst.
REQ-015 First command SHALL be accepted on first clk edge after rst_n deasserts.

Configuration
REQ-016 With REFRESH_SUPPORT_EN defined, REF with all banks IDLE SHALL move all banks to REFRESHING for tRFC cycles, then IDLE; REF with any bank not IDLE SHALL pulse err_state.
REQ-017 Without REFRESH_SUPPORT_EN, op 5 SHALL be treated as illegal (err_state) and REFRESHING state SHALL not exist.

Verification
REQ-018 ACT bank 3 at T=10, RD bank 3 at T=26 -> rd_valid high T=42..45, dq_bank=3, dq_beat 0..3, no errors.
REQ-019 ACT bank 0 at T=10, RD bank 0 at T=20 -> err_timing at T=21, err_count=1, no rd_valid.
REQ-020 Two ACTIVE banks, RD at T=50 and T=52 -> err_collision at T=53, only first burst (T=66..69) appears; RD at T=54 instead -> bursts T=66..69 and T=70..73.
REQ-021 RD to IDLE bank 5 -> err_state next cycle, bank_open unchanged; PRE to IDLE bank -> no error.
REQ-022 rst_n low during burst at T=43 -> rd_valid, bank_open, err_count 0 immediately.
REQ-023 With REFRESH_SUPPORT_EN: REF all IDLE at T=5, ACT at T=100 -> err_timing; ACT at T=261 -> accepted.
